// File: rtl/pipe_pkg.sv
// Types and constants shared by the pipeline memory stage and its dmem interface controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } mem_state_e;

  localparam logic [4:0]  NOP_REGD  = 5'd0;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  regD;
    logic [31:0] val;
  } wb_bundle_t;

endpackage

// File: rtl/dmem_if_ctrl.sv
// Data-memory handshake FSM: latches one word access, waits for ack with a timeout,
// captures load data for the release cycle.
module dmem_if_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             we_i,
  input  logic [4:0]       rd_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             dmem_ack_i,
  input  logic [31:0]      dmem_rdata_i,
  output mem_state_e       state_o,
  output logic [4:0]       rd_o,
  output logic [31:0]      stall_val_o,
  output logic             fault_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [31:0]      dmem_addr_o,
  output logic [31:0]      dmem_wdata_o
);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;
  logic [31:0]      addr_q, wdata_q, stall_val_q;
  logic             we_q, req_q, fault_q;

  // cnt_q holds the number of WAIT cycles spent so far, including the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      stall_val_q <= '0;
      we_q        <= 1'b0;
      req_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      unique case (state_q)
        IDLE, RELEASE: begin
          cnt_q <= '0;
          if (start_i) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(1);
            req_q   <= 1'b1;
            we_q    <= we_i;
            rd_q    <= rd_i;
            addr_q  <= addr_i & WORD_MASK;
            wdata_q <= wdata_i;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            if (we_q) begin
              state_q <= IDLE;
            end else begin
              state_q     <= RELEASE;
              stall_val_q <= dmem_rdata_i;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            fault_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o      = state_q;
  assign rd_o         = rd_q;
  assign stall_val_o  = stall_val_q;
  assign fault_o      = fault_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: word load/store over dmem, stall generation, forwarding,
// branch/jump flush and the registered writeback bundle.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwrite,
  input  logic        loadF,
  input  logic        storeF,
  input  logic        branchF,
  input  logic        jalF,
  input  logic        jalrF,
  input  logic [31:0] target,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic        branch_cond,
  input  logic [4:0]  regDF,
  output logic        stall,
  output logic [31:0] stall_val,
  output logic [4:0]  regD_mem,
  output logic [31:0] regD_val_mem,
  output logic        regwrite_mem,
  output logic        branch_flush,
  output logic        jal_flush,
  output logic [31:0] redirect_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_regwrite,
  output logic [4:0]  wb_regD,
  output logic [31:0] wb_val,
  output logic        mem_fault
);

  mem_state_e  state;
  logic [4:0]  rd_lat;
  logic        mem_op, accept;
  wb_bundle_t  wb_d, wb_q;

  assign mem_op = loadF | storeF;
  // RELEASE accepts a new instruction exactly like IDLE.
  assign accept = (state == IDLE) || (state == RELEASE);

  dmem_if_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_dmem_if_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start_i      (accept && mem_op),
    .we_i         (storeF),
    .rd_i         (regDF),
    .addr_i       (result),
    .wdata_i      (store_data),
    .dmem_ack_i   (dmem_ack),
    .dmem_rdata_i (dmem_rdata),
    .state_o      (state),
    .rd_o         (rd_lat),
    .stall_val_o  (stall_val),
    .fault_o      (mem_fault),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata)
  );

  assign stall = (state == WAIT);

  always_comb begin
    regD_mem     = regDF;
    regD_val_mem = result;
    regwrite_mem = 1'b0;
    unique case (state)
      WAIT: begin
        regD_mem     = rd_lat;
        regD_val_mem = '0;
      end
      RELEASE: begin
        regD_mem     = rd_lat;
        regD_val_mem = stall_val;
        regwrite_mem = (rd_lat != NOP_REGD);
      end
      default: regwrite_mem = regwrite && !mem_op && (regDF != NOP_REGD);
    endcase
  end

  assign branch_flush = (state == IDLE) && branchF && branch_cond;
  assign jal_flush    = (state == IDLE) && (jalF || jalrF);
  assign redirect_pc  = (branch_flush || jal_flush) ? target : '0;

  // Loads write back from RELEASE; stores and WAIT cycles are bubbles.
  always_comb begin
    wb_d = '0;
    unique case (state)
      WAIT:    wb_d = '0;
      RELEASE: begin
        wb_d.regwrite = (rd_lat != NOP_REGD);
        wb_d.regD     = rd_lat;
        wb_d.val      = stall_val;
      end
      default: begin
        if (!mem_op) begin
          wb_d.regwrite = regwrite;
          wb_d.regD     = regDF;
          wb_d.val      = result;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_regwrite = wb_q.regwrite;
  assign wb_regD     = wb_q.regD;
  assign wb_val      = wb_q.val;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random traffic against a transaction-level model.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk, rst;
  logic        regwrite, loadF, storeF, branchF, jalF, jalrF, branch_cond;
  logic [31:0] target, result, store_data, dmem_rdata;
  logic [4:0]  regDF;
  logic        dmem_ack;
  logic        stall, regwrite_mem, branch_flush, jal_flush, dmem_req, dmem_we;
  logic        wb_regwrite, mem_fault;
  logic [31:0] stall_val, regD_val_mem, redirect_pc, dmem_addr, dmem_wdata, wb_val;
  logic [4:0]  regD_mem, wb_regD;

  int total = 0;
  int bad   = 0;

  // Model: an access in flight, how many wait cycles it has used, and the last latched request.
  bit          m_wait, m_rel, m_we, m_fault, m_wb_rw;
  int          m_wait_cnt;
  logic [4:0]  m_rd, m_wb_rd;
  logic [31:0] m_addr, m_wdata, m_sval, m_wb_val;

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .regwrite(regwrite), .loadF(loadF), .storeF(storeF),
    .branchF(branchF), .jalF(jalF), .jalrF(jalrF), .target(target), .result(result),
    .store_data(store_data), .branch_cond(branch_cond), .regDF(regDF), .stall(stall),
    .stall_val(stall_val), .regD_mem(regD_mem), .regD_val_mem(regD_val_mem),
    .regwrite_mem(regwrite_mem), .branch_flush(branch_flush), .jal_flush(jal_flush),
    .redirect_pc(redirect_pc), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_regwrite(wb_regwrite), .wb_regD(wb_regD), .wb_val(wb_val),
    .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_rel = 0; m_we = 0; m_fault = 0; m_wb_rw = 0; m_wait_cnt = 0;
    m_rd = '0; m_wb_rd = '0; m_addr = '0; m_wdata = '0; m_sval = '0; m_wb_val = '0;
  endtask

  task automatic clear_in();
    regwrite = 0; loadF = 0; storeF = 0; branchF = 0; jalF = 0; jalrF = 0;
    branch_cond = 0; target = '0; result = '0; store_data = '0; regDF = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic check_outputs();
    logic [4:0]  e_rd;
    logic [31:0] e_fv, e_pc;
    logic        e_fw, e_bf, e_jf;
    bit          free;
    free = !m_wait && !m_rel;
    if (m_wait) begin
      e_rd = m_rd; e_fv = '0; e_fw = 0;
    end else if (m_rel) begin
      e_rd = m_rd; e_fv = m_sval; e_fw = (m_rd != 0);
    end else begin
      e_rd = regDF; e_fv = result;
      e_fw = regwrite && !storeF && !loadF && (regDF != 0);
    end
    e_bf = free && branchF && branch_cond;
    e_jf = free && (jalF || jalrF);
    e_pc = (e_bf || e_jf) ? target : 32'h0;
    chk("stall", stall, m_wait);
    chk("dmem_req", dmem_req, m_wait);
    chk("dmem_we", dmem_we, m_we);
    chk("dmem_addr", dmem_addr, m_addr);
    chk("dmem_wdata", dmem_wdata, m_wdata);
    chk("stall_val", stall_val, m_sval);
    chk("mem_fault", mem_fault, m_fault);
    chk("wb_regwrite", wb_regwrite, m_wb_rw);
    chk("wb_regD", wb_regD, m_wb_rd);
    chk("wb_val", wb_val, m_wb_val);
    chk("regD_mem", regD_mem, e_rd);
    chk("regD_val_mem", regD_val_mem, e_fv);
    chk("regwrite_mem", regwrite_mem, e_fw);
    chk("branch_flush", branch_flush, e_bf);
    chk("jal_flush", jal_flush, e_jf);
    chk("redirect_pc", redirect_pc, e_pc);
  endtask

  task automatic model_step();
    bit f;
    f = 0;
    if (m_wait) begin
      m_wait_cnt++;
      m_wb_rw = 0; m_wb_rd = '0; m_wb_val = '0;
      if (dmem_ack) begin
        m_wait = 0;
        if (!m_we) begin
          m_rel  = 1;
          m_sval = dmem_rdata;
        end
      end else if (m_wait_cnt == TO) begin
        m_wait = 0;
        f = 1;
      end
    end else begin
      if (m_rel) begin
        m_wb_rw = (m_rd != 0); m_wb_rd = m_rd; m_wb_val = m_sval;
      end else if (loadF || storeF) begin
        m_wb_rw = 0; m_wb_rd = '0; m_wb_val = '0;
      end else begin
        m_wb_rw = regwrite; m_wb_rd = regDF; m_wb_val = result;
      end
      m_rel = 0;
      if (loadF || storeF) begin
        m_wait = 1; m_wait_cnt = 0; m_we = storeF; m_rd = regDF;
        m_addr = result & 32'hFFFF_FFFC; m_wdata = store_data;
      end
    end
    m_fault = f;
  endtask

  // Inputs are applied at posedge+1; outputs are sampled at posedge+4.
  task automatic cycle();
    #3;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    model_reset();
    rst = 0;
    #12;
    rst = 1;
    @(posedge clk);
    #1;
    cycle();

    // ALU passthrough
    regwrite = 1; regDF = 5'd5; result = 32'h1234;
    #1;
    chk("alu_fwd_val", regD_val_mem, 32'h1234);
    chk("alu_fwd_we", regwrite_mem, 1'b1);
    cycle();
    clear_in();
    chk("alu_wb_val", wb_val, 32'h1234);
    chk("alu_wb_rd", wb_regD, 32'd5);
    cycle();

    // Load acked in the fourth wait cycle
    loadF = 1; regwrite = 1; regDF = 5'd7; result = 32'h103;
    cycle();
    clear_in();
    chk("ld_addr", dmem_addr, 32'h100);
    for (int i = 0; i < 3; i++) cycle();
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    cycle();
    clear_in();
    chk("ld_stall_val", stall_val, 32'hDEAD_BEEF);
    chk("ld_fwd_val", regD_val_mem, 32'hDEAD_BEEF);
    cycle();
    chk("ld_wb_val", wb_val, 32'hDEAD_BEEF);
    cycle();

    // Store
    storeF = 1; regDF = 5'd3; result = 32'h200; store_data = 32'hA5;
    cycle();
    clear_in();
    chk("st_we", dmem_we, 1'b1);
    chk("st_wdata", dmem_wdata, 32'hA5);
    cycle();
    dmem_ack = 1;
    cycle();
    clear_in();
    cycle();
    chk("st_no_wb", wb_regwrite, 1'b0);

    // Taken and not-taken branch
    branchF = 1; branch_cond = 1; target = 32'h80;
    #1;
    chk("br_flush", branch_flush, 1'b1);
    chk("br_pc", redirect_pc, 32'h80);
    cycle();
    branch_cond = 0;
    #1;
    chk("br_nt", branch_flush, 1'b0);
    cycle();
    clear_in();

    // Timeout, then a late ack
    loadF = 1; regDF = 5'd9; result = 32'h40;
    cycle();
    clear_in();
    for (int i = 0; i < TO; i++) cycle();
    chk("to_fault", mem_fault, 1'b1);
    chk("to_req", dmem_req, 1'b0);
    dmem_ack = 1; dmem_rdata = 32'h5555_0000;
    cycle();
    clear_in();
    chk("to_fault_pulse", mem_fault, 1'b0);
    cycle();

    // Ack coincides with the timeout cycle
    loadF = 1; regDF = 5'd4; result = 32'h44;
    cycle();
    clear_in();
    for (int i = 0; i < TO - 1; i++) cycle();
    dmem_ack = 1; dmem_rdata = 32'h0BAD_F00D;
    cycle();
    clear_in();
    chk("race_no_fault", mem_fault, 1'b0);
    cycle();
    cycle();

    // Asynchronous reset in the middle of a wait
    loadF = 1; regDF = 5'd6; result = 32'h88;
    cycle();
    clear_in();
    cycle();
    rst = 0;
    #1;
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    cycle();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int op;
      clear_in();
      op          = $urandom_range(0, 5);
      regDF       = 5'($urandom_range(0, 31));
      result      = $urandom;
      target      = $urandom;
      store_data  = $urandom;
      branch_cond = 1'($urandom_range(0, 1));
      regwrite    = 1'($urandom_range(0, 1));
      unique case (op)
        1: begin loadF = 1; regwrite = 1; end
        2: begin storeF = 1; regwrite = 0; end
        3: begin branchF = 1; regwrite = 0; end
        4: begin jalF = 1; regwrite = 1; end
        5: begin jalrF = 1; regwrite = 1; end
        default: ;
      endcase
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
